// File: rtl/glitch_stim_seq.sv
// glitch_stim_seq: stimulus sequencer for the glitch datapath.
// Walks {a,c} through patterns 0..3 and fires a b pulse under each one.
// The whole 4-pattern sweep repeats repeat_n times.
// Optional feature macro: GLITCH_STIM_TOGGLE_CNT_EN counts out_obs transitions while busy.
// Without the macro, toggle_cnt is tied to zero and out_obs is ignored.
module glitch_stim_seq #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES  = 1,
    parameter int unsigned REPEAT_W     = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [REPEAT_W-1:0] repeat_n,
    input  logic                abort,
    input  logic                out_obs,
    output logic                a,
    output logic                b,
    output logic                c,
    output logic [1:0]          pattern,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    toggle_cnt
);

    localparam int unsigned MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
    localparam int unsigned PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

    state_e              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [1:0]          pat_q, pat_d;
    logic [REPEAT_W-1:0] rep_q, rep_d;
    logic                done_d;
    logic                accept;
    logic                a_q, b_q, c_q, busy_q, done_q;
    logic                a_d, b_d, c_d, busy_d;

    // State register plus registered output drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ph_q    <= '0;
            pat_q   <= '0;
            rep_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state: phase timing, pattern walk, repeat accounting, abort.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        if (state_q != StIdle && abort) begin
            state_d = StIdle;
            ph_d    = '0;
            pat_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Abort beats start in the same idle cycle.
                    if (start && !abort) begin
                        if (repeat_n != '0) begin
                            state_d = StSetup;
                            ph_d    = '0;
                            pat_d   = '0;
                            rep_d   = repeat_n;
                            accept  = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StSetup: begin
                    if (ph_q == SETUP_LAST) begin
                        state_d = StPulse;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                StPulse: begin
                    if (ph_q == PULSE_LAST) begin
                        state_d = StHold;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                StHold: begin
                    if (ph_q == HOLD_LAST) begin
                        ph_d = '0;
                        if (pat_q != 2'd3) begin
                            pat_d   = pat_q + 2'd1;
                            state_d = StSetup;
                        end else if (rep_q > REPEAT_W'(1)) begin
                            rep_d   = rep_q - REPEAT_W'(1);
                            pat_d   = '0;
                            state_d = StSetup;
                        end else begin
                            pat_d   = '0;
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output decode of the next state; registered above so drives are glitch-free.
    always_comb begin
        busy_d = (state_d != StIdle);
        a_d    = busy_d & pat_d[1];
        c_d    = busy_d & pat_d[0];
        b_d    = (state_d == StPulse);
    end

    assign a       = a_q;
    assign b       = b_q;
    assign c       = c_q;
    assign pattern = pat_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef GLITCH_STIM_TOGGLE_CNT_EN
    logic             out_prev;
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of out_obs transitions while a run is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_prev <= 1'b0;
            cnt_q    <= '0;
        end else begin
            out_prev <= out_obs;
            if (accept) begin
                cnt_q <= '0;
            end else if (busy_q && (out_obs != out_prev) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign toggle_cnt = cnt_q;
`else
    logic unused_obs;
    assign unused_obs = out_obs ^ accept;
    assign toggle_cnt = '0;
`endif

endmodule
